seg7_to_hex_capture: RTL and testbench
======================================

// Module: seg7_to_hex_capture
// PURPOSE
//   Inverse of the team's hex-to-7-segment encoder: watches an active-low 7-segment
//   pattern bus, waits for each pattern to stay stable, and decodes it back to a hex
//   nibble. Decoded nibbles are assembled into a NUM_DIGITS-digit word.
//   Used as a display-side monitor and self-check: loop back the encoder output and
//   compare the recovered value with the source.
// PARAMETERS
//   NUM_DIGITS     4   digits per assembled word (>=1); word width = 4*NUM_DIGITS
//   STABLE_CYCLES  3   consecutive identical samples required to accept a pattern (1..255)
// PORTS
//   clk         in   1              system clock, rising edge
//   reset       in   1              asynchronous, active-high reset
//   seg_in      in   7              active-low segments, bit0=a .. bit6=g
//   seg_en      in   1              qualifier; seg_in is ignored while low
//   out_valid   out  1              one-cycle pulse: a stable pattern was accepted
//   out_hex     out  4              decoded nibble; holds until next out_valid
//   out_err     out  1              with out_valid: pattern is not one of the 16 codes
//   digit_idx   out  clog2(NUM_DIGITS) (min 1)   next digit position in the word
//   word        out  4*NUM_DIGITS   assembled word, newest digit in bits [3:0]
//   word_valid  out  1              one-cycle pulse: word just completed
// BEHAVIOUR
// - Reset (async, any time): all outputs 0, stable count 0, FSM IDLE, sample reg 7'h7F.
// - seg_in and seg_en are registered once (seg_q, en_q). All decisions use the
//   registered values.
// - FSM:
//   - IDLE: en_q=0 -> stay. en_q=1 -> SETTLE, cnt=1.
//   - SETTLE: en_q=0 -> IDLE.
//     - seg_q differs from the previous seg_q -> cnt=1.
//     - Otherwise cnt increments.
//     - cnt reaches STABLE_CYCLES -> accept and go to HELD.
//   - HELD: en_q=0 -> IDLE. seg_q change -> SETTLE, cnt=1. Otherwise stay; no re-emit.
// - Latency: a pattern first sampled into seg_q at edge e (seg_en high throughout)
//   gives out_valid high for exactly the cycle after edge e+STABLE_CYCLES-1.
//   With STABLE_CYCLES=1, acceptance happens on the first sample.
// - Accept actions:
//   - Decode table is the exact inverse of the team encoder:
//     - 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78
//     - 8:00 9:18 A:08 b:03 C:46 d:21 E:06 F:0E (hex of 7-bit pattern)
//   - Pattern 7'h7F (blank): accepted silently. No out_valid; word and digit_idx unchanged.
//   - Valid code:
//     - out_valid=1, out_err=0, out_hex=nibble.
//     - word <= {word[4*NUM_DIGITS-5:0], nibble}; digit_idx++.
//     - If digit_idx was NUM_DIGITS-1: word_valid=1 that same cycle, digit_idx wraps to 0.
//   - Any other pattern:
//     - out_valid=1, out_err=1, out_hex=0.
//     - digit_idx <= 0; word is kept. This aborts the partial word; no word_valid.
// - out_valid, out_err and word_valid are registered, one cycle wide, never back-to-back.
//   An acceptance needs at least one more sample, so the minimum spacing is 2 cycles.
// - seg_en dropping during SETTLE discards the pending pattern; digit_idx is kept.
// - Counter saturates at STABLE_CYCLES. It has no wrap-around for long holds.
// TESTING
// 1. Reset asserted mid-SETTLE with digit_idx=2 -> all outputs 0 immediately (async);
//    no out_valid after release until a fresh stable run.
// 2. STABLE_CYCLES=3, seg_en=1, sweep the 16 codes, each held 5 cycles ->
//    out_hex=0..F in order, out_err=0, one out_valid per code, 3 cycles after the
//    pattern is first sampled.
// 3. Glitch: 7'h24 held 2 cycles, then 7'h30 held 4 cycles -> exactly one out_valid,
//    out_hex=3; no pulse for 2.
// 4. Word: 7'h79,7'h24,7'h30,7'h19, each 4 cycles, separated by a 7'h7F gap ->
//    word=16'h1234, word_valid one cycle, digit_idx=0. The blanks add no pulses.
// 5. Error: 7'h7E held 4 cycles after two valid digits -> out_valid=1, out_err=1,
//    digit_idx=0, word unchanged.
// 6. Long hold of 7'h00 for 300 cycles -> single out_valid, out_hex=8; seg_en low then
//    high with the same pattern -> second out_valid.

Source files
------------

// File: rtl/seg7_to_hex_capture.sv
// Recovers hex nibbles from an active-low 7-segment bus once each pattern has
// stayed stable, and assembles them into a NUM_DIGITS-digit word.
module seg7_to_hex_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 3,
    localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
    localparam int WORD_W       = 4 * NUM_DIGITS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [6:0]        seg_in,
    input  logic              seg_en,
    output logic              out_valid,
    output logic [3:0]        out_hex,
    output logic              out_err,
    output logic [IDX_W-1:0]  digit_idx,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HELD
    } state_t;

    localparam logic [7:0]       CNT_TARGET = 8'(STABLE_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]       BLANK      = 7'h7F;

    state_t             state_q, state_d;
    logic [6:0]         seg_q, prev_q;
    logic               en_q;
    logic [7:0]         cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [3:0]         out_hex_q, out_hex_d;
    logic               out_err_q, out_err_d;
    logic [IDX_W-1:0]   digit_idx_q, digit_idx_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic               word_valid_q, word_valid_d;
    logic               accept;
    logic [4:0]         decoded;

    // Bit 4 flags a recognised code; bits [3:0] carry the nibble.
    function automatic logic [4:0] decode(input logic [6:0] pat);
        logic [4:0] res;
        case (pat)
            7'h40:   res = 5'h10;
            7'h79:   res = 5'h11;
            7'h24:   res = 5'h12;
            7'h30:   res = 5'h13;
            7'h19:   res = 5'h14;
            7'h12:   res = 5'h15;
            7'h02:   res = 5'h16;
            7'h78:   res = 5'h17;
            7'h00:   res = 5'h18;
            7'h18:   res = 5'h19;
            7'h08:   res = 5'h1A;
            7'h03:   res = 5'h1B;
            7'h46:   res = 5'h1C;
            7'h21:   res = 5'h1D;
            7'h06:   res = 5'h1E;
            7'h0E:   res = 5'h1F;
            default: res = 5'h00;
        endcase
        return res;
    endfunction

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        accept       = 1'b0;
        out_valid_d  = 1'b0;
        out_err_d    = 1'b0;
        word_valid_d = 1'b0;
        out_hex_d    = out_hex_q;
        digit_idx_d  = digit_idx_q;
        word_d       = word_q;
        decoded      = decode(seg_q);

        // A change seen while HELD only restarts settling, so two acceptances
        // are always separated by at least one further sample.
        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (en_q) begin
                    state_d = SETTLE;
                    cnt_d   = 8'd1;
                    accept  = (cnt_d >= CNT_TARGET);
                end
            end
            SETTLE: begin
                if (!en_q) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    if (seg_q != prev_q) begin
                        cnt_d = 8'd1;
                    end else if (cnt_q < CNT_TARGET) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                    accept = (cnt_d >= CNT_TARGET);
                end
            end
            HELD: begin
                if (!en_q) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else if (seg_q != prev_q) begin
                    state_d = SETTLE;
                    cnt_d   = 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        if (accept) begin
            state_d = HELD;
            if (seg_q == BLANK) begin
                state_d = HELD;
            end else if (decoded[4]) begin
                out_valid_d = 1'b1;
                out_hex_d   = decoded[3:0];
                word_d      = (word_q << 4) | WORD_W'(decoded[3:0]);
                if (digit_idx_q == LAST_IDX) begin
                    digit_idx_d  = '0;
                    word_valid_d = 1'b1;
                end else begin
                    digit_idx_d = digit_idx_q + IDX_W'(1);
                end
            end else begin
                out_valid_d = 1'b1;
                out_err_d   = 1'b1;
                out_hex_d   = 4'h0;
                digit_idx_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            seg_q        <= BLANK;
            prev_q       <= BLANK;
            en_q         <= 1'b0;
            cnt_q        <= 8'd0;
            out_valid_q  <= 1'b0;
            out_hex_q    <= 4'h0;
            out_err_q    <= 1'b0;
            digit_idx_q  <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            seg_q        <= seg_in;
            prev_q       <= seg_q;
            en_q         <= seg_en;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_hex_q    <= out_hex_d;
            out_err_q    <= out_err_d;
            digit_idx_q  <= digit_idx_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_hex    = out_hex_q;
    assign out_err    = out_err_q;
    assign digit_idx  = digit_idx_q;
    assign word       = word_q;
    assign word_valid = word_valid_q;

endmodule

// File: tb/tb_seg7_to_hex_capture.sv
// Directed bench for seg7_to_hex_capture (NUM_DIGITS=4, STABLE_CYCLES=3);
// pulses are tallied on the falling edge while patterns are held.
module tb_seg7_to_hex_capture;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  seg_in = 7'h7F;
    logic        seg_en = 1'b0;
    logic        out_valid;
    logic [3:0]  out_hex;
    logic        out_err;
    logic [1:0]  digit_idx;
    logic [15:0] word;
    logic        word_valid;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int pulse_at = -1;
    int word_pulses = 0;
    int back_to_back = 0;
    int sweep_words = 0;
    logic [3:0] last_hex = 4'h0;
    logic       last_err = 1'b0;
    logic       prev_valid = 1'b0;

    logic [6:0] codes [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg7_to_hex_capture #(
        .NUM_DIGITS    (4),
        .STABLE_CYCLES (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .seg_in     (seg_in),
        .seg_en     (seg_en),
        .out_valid  (out_valid),
        .out_hex    (out_hex),
        .out_err    (out_err),
        .digit_idx  (digit_idx),
        .word       (word),
        .word_valid (word_valid)
    );

    always #5 clk = ~clk;

    // Advances n rising edges, sampling outputs on each following falling edge.
    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (out_valid) begin
                pulses++;
                pulse_at = i;
                last_hex = out_hex;
                last_err = out_err;
                if (prev_valid) back_to_back++;
            end
            prev_valid = out_valid;
            if (word_valid) word_pulses++;
        end
    endtask

    task automatic applyStimulus(input logic [6:0] seg, input logic en, input int n);
        seg_in = seg;
        seg_en = en;
        runCycles(n);
    endtask

    task automatic clearCounts();
        pulses = 0;
        pulse_at = -1;
        word_pulses = 0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        seg_in = 7'h7F;
        seg_en = 1'b0;
        runCycles(2);
        reset = 1'b0;
        applyStimulus(7'h7F, 1'b1, 5);
        clearCounts();
    endtask

    initial begin
        // Reset state
        doReset();
        checkOutput("rst_valid", 32'(out_valid), 32'h0);
        checkOutput("rst_word", 32'(word), 32'h0);
        checkOutput("rst_idx", 32'(digit_idx), 32'h0);
        checkOutput("blank_no_pulse", pulses, 0);

        // Async reset in the middle of settling with two digits captured
        applyStimulus(7'h79, 1'b1, 4);
        applyStimulus(7'h24, 1'b1, 4);
        checkOutput("pre_rst_idx", 32'(digit_idx), 32'h2);
        checkOutput("pre_rst_word", 32'(word), 32'h0012);
        applyStimulus(7'h30, 1'b1, 2);
        reset = 1'b1;
        #1;
        checkOutput("async_valid", 32'(out_valid), 32'h0);
        checkOutput("async_hex", 32'(out_hex), 32'h0);
        checkOutput("async_err", 32'(out_err), 32'h0);
        checkOutput("async_idx", 32'(digit_idx), 32'h0);
        checkOutput("async_word", 32'(word), 32'h0);
        checkOutput("async_wvalid", 32'(word_valid), 32'h0);
        runCycles(1);
        reset = 1'b0;
        clearCounts();
        applyStimulus(7'h30, 1'b1, 2);
        checkOutput("post_rst_quiet", pulses, 0);
        applyStimulus(7'h30, 1'b1, 3);
        checkOutput("post_rst_pulse", pulses, 1);
        checkOutput("post_rst_hex", 32'(last_hex), 32'h3);
        checkOutput("post_rst_idx", 32'(digit_idx), 32'h1);

        // Sweep all 16 codes, each held 5 cycles
        doReset();
        sweep_words = 0;
        for (int i = 0; i < 16; i++) begin
            clearCounts();
            applyStimulus(codes[i], 1'b1, 5);
            checkOutput("sweep_pulses", pulses, 1);
            checkOutput("sweep_latency", pulse_at, 3);
            checkOutput("sweep_hex", 32'(last_hex), 32'(i));
            checkOutput("sweep_err", 32'(last_err), 32'h0);
            sweep_words += word_pulses;
        end
        checkOutput("sweep_word_pulses", sweep_words, 4);
        checkOutput("sweep_word", 32'(word), 32'hCDEF);
        checkOutput("sweep_idx", 32'(digit_idx), 32'h0);

        // Glitch: short 2 then stable 3
        doReset();
        applyStimulus(7'h24, 1'b1, 2);
        applyStimulus(7'h30, 1'b1, 4);
        checkOutput("glitch_pulses", pulses, 1);
        checkOutput("glitch_hex", 32'(last_hex), 32'h3);

        // Word assembly 1,2,3,4 with blank gaps
        doReset();
        applyStimulus(7'h79, 1'b1, 4);
        applyStimulus(7'h7F, 1'b1, 4);
        applyStimulus(7'h24, 1'b1, 4);
        applyStimulus(7'h7F, 1'b1, 4);
        applyStimulus(7'h30, 1'b1, 4);
        applyStimulus(7'h7F, 1'b1, 4);
        applyStimulus(7'h19, 1'b1, 4);
        applyStimulus(7'h7F, 1'b1, 4);
        checkOutput("word_pulses", pulses, 4);
        checkOutput("word_done", word_pulses, 1);
        checkOutput("word_value", 32'(word), 32'h1234);
        checkOutput("word_idx", 32'(digit_idx), 32'h0);

        // Invalid pattern after two digits aborts the partial word
        applyStimulus(7'h79, 1'b1, 4);
        applyStimulus(7'h7F, 1'b1, 4);
        applyStimulus(7'h24, 1'b1, 4);
        applyStimulus(7'h7F, 1'b1, 4);
        checkOutput("err_pre_idx", 32'(digit_idx), 32'h2);
        clearCounts();
        applyStimulus(7'h7E, 1'b1, 4);
        checkOutput("err_pulses", pulses, 1);
        checkOutput("err_flag", 32'(last_err), 32'h1);
        checkOutput("err_hex", 32'(last_hex), 32'h0);
        checkOutput("err_idx", 32'(digit_idx), 32'h0);
        checkOutput("err_word", 32'(word), 32'h3412);
        checkOutput("err_no_word", word_pulses, 0);

        // Long hold, then seg_en drop and return with the same pattern
        clearCounts();
        applyStimulus(7'h00, 1'b1, 300);
        checkOutput("hold_pulses", pulses, 1);
        checkOutput("hold_hex", 32'(last_hex), 32'h8);
        clearCounts();
        applyStimulus(7'h00, 1'b0, 3);
        checkOutput("en_low_quiet", pulses, 0);
        applyStimulus(7'h00, 1'b1, 5);
        checkOutput("reen_pulses", pulses, 1);
        checkOutput("reen_hex", 32'(last_hex), 32'h8);
        checkOutput("reen_idx", 32'(digit_idx), 32'h2);
        checkOutput("reen_word", 32'(word), 32'h1288);

        checkOutput("no_back_to_back", back_to_back, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
